// File: rtl/atp_top_level_module.sv
// atp_top_level_module: self-service checkout FSM (menu, scan, pay, print) with edge-detected
// touch/scan inputs, timeout on idle menu/payment, and a timed receipt acknowledge.
module atp_top_level_module #(
  parameter logic [9:0] BILL_AMOUNT    = 10'd100,
  parameter int         SCAN_CYCLES    = 2,
  parameter int         PRINT_CYCLES   = 4,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       user_touch,
  input  logic       scan_start,
  input  logic [9:0] cash_inserted,
  output logic       ack_printed
);
  localparam int MAXP = (TIMEOUT_CYCLES > SCAN_CYCLES) ?
                        ((TIMEOUT_CYCLES > PRINT_CYCLES) ? TIMEOUT_CYCLES : PRINT_CYCLES) :
                        ((SCAN_CYCLES > PRINT_CYCLES) ? SCAN_CYCLES : PRINT_CYCLES);
  localparam int CW = $clog2(MAXP + 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] PRINT_LAST = CW'(PRINT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, MENU = 3'd1, SCAN = 3'd2, PAY = 3'd3, PRINT = 3'd4} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [9:0]    bill_q, change_q, cash_q;
  logic          touch_q, scan_q, ack_q;
  logic          touch_edge, scan_edge, cash_chg;

  assign touch_edge  = user_touch & ~touch_q;
  assign scan_edge   = scan_start & ~scan_q;
  assign cash_chg    = cash_inserted != cash_q;
  assign ack_printed = ack_q;

  // cnt_q is shared by every timed state; it only increments below its limit, so it never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bill_q   <= '0;
      change_q <= '0;
      cash_q   <= '0;
      touch_q  <= 1'b0;
      scan_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      touch_q <= user_touch;
      scan_q  <= scan_start;
      cash_q  <= cash_inserted;
      case (state_q)
        IDLE: if (touch_edge) begin
          state_q <= MENU;
          cnt_q   <= '0;
        end
        MENU: if (scan_edge) begin
          state_q <= SCAN;
          cnt_q   <= '0;
        end else if (cnt_q == TO_LAST) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        SCAN: if (cnt_q == SCAN_LAST) begin
          state_q <= PAY;
          cnt_q   <= '0;
          bill_q  <= BILL_AMOUNT;
        end else cnt_q <= cnt_q + 1'b1;
        PAY: if (cash_inserted >= bill_q) begin
          state_q  <= PRINT;
          cnt_q    <= '0;
          change_q <= cash_inserted - bill_q;
          ack_q    <= 1'b1;
        end else if (cash_chg) cnt_q <= '0;
        else if (cnt_q == TO_LAST) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          bill_q  <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        PRINT: if (cnt_q == PRINT_LAST) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          ack_q    <= 1'b0;
          bill_q   <= '0;
          change_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_atp_top_level_module.sv
// tb_atp_top_level_module: directed scenarios plus random traffic, checked every cycle
// against a countdown-style behavioural model of the checkout flow.
module tb_atp_top_level_module;
  localparam int BILL = 100, SCANC = 2, PRINTC = 4, TOC = 255;
  localparam int S_IDLE = 0, S_MENU = 1, S_SCAN = 2, S_PAY = 3, S_PRINT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       user_touch = 1'b0;
  logic       scan_start = 1'b0;
  logic [9:0] cash_inserted = '0;
  logic       ack_printed;

  int checks = 0, errors = 0, ack_cnt = 0;

  atp_top_level_module dut (
    .clk(clk), .reset(reset), .user_touch(user_touch), .scan_start(scan_start),
    .cash_inserted(cash_inserted), .ack_printed(ack_printed)
  );

  always #5 clk = ~clk;

  // model: phase plus cycles left in that phase
  int   m_st = S_IDLE, m_left = 0, m_bill = 0, m_change = 0;
  bit   m_ack = 0, m_pt = 0, m_ps = 0, te, se, chg;
  int   m_pc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st = S_IDLE; m_left = 0; m_bill = 0; m_change = 0; m_ack = 0;
      m_pt = 0; m_ps = 0; m_pc = 0;
    end else begin
      te = user_touch && !m_pt;
      se = scan_start && !m_ps;
      chg = int'(cash_inserted) != m_pc;
      m_pt = user_touch; m_ps = scan_start; m_pc = int'(cash_inserted);
      case (m_st)
        S_IDLE: if (te) begin m_st = S_MENU; m_left = TOC; end
        S_MENU: if (se) begin m_st = S_SCAN; m_left = SCANC; end
                else begin m_left--; if (m_left == 0) m_st = S_IDLE; end
        S_SCAN: begin
          m_left--;
          if (m_left == 0) begin m_st = S_PAY; m_bill = BILL; m_left = TOC; end
        end
        S_PAY: if (int'(cash_inserted) >= BILL) begin
          m_st = S_PRINT; m_change = int'(cash_inserted) - BILL; m_ack = 1; m_left = PRINTC;
        end else if (chg) m_left = TOC;
        else begin
          m_left--;
          if (m_left == 0) begin m_st = S_IDLE; m_bill = 0; end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin m_st = S_IDLE; m_ack = 0; m_bill = 0; m_change = 0; end
        end
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ack", int'(ack_printed), int'(m_ack));
    chk("state", int'(dut.state_q), m_st);
    chk("bill", int'(dut.bill_q), m_bill);
    chk("change", int'(dut.change_q), m_change);
    if (ack_printed) ack_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_touch;
    user_touch = 1'b1; tick(1); user_touch = 1'b0;
  endtask

  task automatic pulse_scan;
    scan_start = 1'b1; tick(1); scan_start = 1'b0;
  endtask

  task automatic txn;
    pulse_touch; tick(1); pulse_scan;
  endtask

  task automatic do_reset;
    reset = 1'b0; tick(2); reset = 1'b1; tick(1);
  endtask

  initial begin
    tick(2);
    chk("reset_ack", int'(ack_printed), 0);
    chk("reset_state", int'(dut.state_q), S_IDLE);
    reset = 1'b1; tick(2);

    // nominal exact payment
    ack_cnt = 0; cash_inserted = 10'd100;
    txn; tick(2);
    chk("nom_pay_state", int'(dut.state_q), S_PAY);
    chk("nom_no_ack_yet", int'(ack_printed), 0);
    tick(1);
    chk("nom_ack_start", int'(ack_printed), 1);
    tick(30);
    chk("nom_ack_count", ack_cnt, 4);
    chk("nom_idle", int'(dut.state_q), S_IDLE);
    tick(10);
    chk("nom_no_more_ack", ack_cnt, 4);

    // overpay
    ack_cnt = 0; cash_inserted = 10'd250;
    txn; tick(3);
    chk("over_ack", int'(ack_printed), 1);
    chk("over_change", int'(dut.change_q), 150);
    chk("model_over_change", m_change, 150);
    tick(30);
    chk("over_ack_count", ack_cnt, 4);
    chk("over_change_cleared", int'(dut.change_q), 0);

    // underpay timeout
    ack_cnt = 0; cash_inserted = 10'd60;
    txn; tick(200);
    chk("under_still_pay", int'(dut.state_q), S_PAY);
    tick(100);
    chk("under_idle", int'(dut.state_q), S_IDLE);
    chk("under_no_ack", ack_cnt, 0);

    // scan before touch, then menu timeout
    pulse_scan; tick(3);
    chk("order_idle", int'(dut.state_q), S_IDLE);
    pulse_touch; tick(3);
    chk("order_menu", int'(dut.state_q), S_MENU);
    tick(260);
    chk("menu_timeout", int'(dut.state_q), S_IDLE);
    pulse_scan; tick(3);
    chk("late_scan_ignored", int'(dut.state_q), S_IDLE);

    // simultaneous touch and scan in IDLE
    user_touch = 1'b1; scan_start = 1'b1; tick(1);
    user_touch = 1'b0; scan_start = 1'b0; tick(4);
    chk("both_edges_menu", int'(dut.state_q), S_MENU);
    do_reset;

    // reset abort in the 2nd ack cycle
    cash_inserted = 10'd100;
    txn; tick(3);
    chk("abort_ack_1st", int'(ack_printed), 1);
    tick(1);
    chk("abort_ack_2nd", int'(ack_printed), 1);
    reset = 1'b0; #1;
    chk("abort_ack_drop", int'(ack_printed), 0);
    chk("abort_state", int'(dut.state_q), S_IDLE);
    tick(2); reset = 1'b1; tick(2);
    chk("abort_after_state", int'(dut.state_q), S_IDLE);
    chk("abort_after_ack", int'(ack_printed), 0);

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      user_touch = ($urandom_range(0, 7) == 0);
      scan_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) cash_inserted = 10'($urandom_range(0, 300));
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0; #2; reset = 1'b1;
      end
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
